// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control unit.
// States 10/11 are used only when MIPS_CTRL_ADDI_EN is defined.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_outdec.sv
// Moore output decoder: datapath controls from the current state, with the
// FETCH IR/PC loads qualified by mem_ready. ADDI states need MIPS_CTRL_ADDI_EN.
module multicycle_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        // Branch target precomputed while the opcode is decoded
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALUOP_FUNC;
      end
      S_R_WB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_RT;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
`ifdef MIPS_CTRL_ADDI_EN
      S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Multicycle MIPS main control FSM: state register, next-state logic and reset
// gating of the write enables. Define MIPS_CTRL_ADDI_EN to support addi.
module multicycle_main_control
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUOp,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_out
);

  state_t state;
  state_t next_state;
  logic   illegal;
  ctrl_t  ctrl;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = S_FETCH;
    illegal    = 1'b0;
    case (state)
      S_FETCH:  next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     next_state = S_R_EXEC;
          OP_LW, OP_SW: next_state = S_MEM_ADDR;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
`ifdef MIPS_CTRL_ADDI_EN
          OP_ADDI:      next_state = S_ADDI_EXEC;
`endif
          default: begin
            next_state = S_FETCH;
            illegal    = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        if (opcode == OP_LW)      next_state = S_MEM_READ;
        else if (opcode == OP_SW) next_state = S_MEM_WRITE;
        else                      next_state = S_FETCH;
      end
      S_MEM_READ:  next_state = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    next_state = S_FETCH;
      S_MEM_WRITE: next_state = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC:    next_state = S_R_WB;
      S_R_WB:      next_state = S_FETCH;
      S_BRANCH:    next_state = S_FETCH;
      S_JUMP:      next_state = S_FETCH;
`ifdef MIPS_CTRL_ADDI_EN
      S_ADDI_EXEC: next_state = S_ADDI_WB;
      S_ADDI_WB:   next_state = S_FETCH;
`endif
      default:     next_state = S_FETCH;
    endcase
  end

  multicycle_ctrl_outdec u_outdec (
    .state     (state),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Enables are masked by reset directly so they drop without a clock edge
  assign PCWrite     = ctrl.pc_write      & ~reset;
  assign PCWriteCond = ctrl.pc_write_cond & ~reset;
  assign MemRead     = ctrl.mem_read      & ~reset;
  assign MemWrite    = ctrl.mem_write     & ~reset;
  assign IRWrite     = ctrl.ir_write      & ~reset;
  assign RegWrite    = ctrl.reg_write     & ~reset;
  assign illegal_op  = illegal            & ~reset;

  assign IorD      = ctrl.i_or_d;
  assign MemtoReg  = ctrl.mem_to_reg;
  assign PCSource  = ctrl.pc_source;
  assign ALUOp     = ctrl.alu_op;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign RegDst    = ctrl.reg_dst;
  assign state_out = STATE_W'(state);

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Moore FSM main control unit for the multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback. Drives every datapath enable and mux select.
- Generates the 2-bit ALUOp consumed by the ALU control decoder:
  - 00 = add
  - 01 = subtract
  - 10 = decode from funct
- Waits on a memory ready handshake for every memory access.

Parameters:
- STATE_W, 4, width of the state register and of state_out.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- opcode  input  6  instruction[31:26] from the instruction register.
- mem_ready  input  1  memory completes the current access this cycle.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load qualified by ALU zero.
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- MemtoReg  output  1  register writeback select: 1 = MDR.
- IRWrite  output  1  instruction register load.
- PCSource  output  2  PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- ALUOp  output  2  to the ALU control decoder.
- ALUSrcA  output  1  ALU A select: 0 = PC, 1 = rs register.
- ALUSrcB  output  2  ALU B select: 00 = rt register, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate.
- RegWrite  output  1  register file write.
- RegDst  output  1  register destination select: 1 = rd, 0 = rt.
- illegal_op  output  1  one-cycle pulse on an unsupported opcode.
- state_out  output  STATE_W  current state, for debug.

Behaviour:
- Reset is asynchronous: state goes to FETCH (0).
  - While reset is high, PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite and illegal_op are forced to 0.
  - All other outputs take their FETCH values.
- Outputs decode combinationally from the state only. The sole exceptions are the mem_ready qualifiers in FETCH.
- Any output not listed for a state is 0.
- State encoding and outputs:
  - FETCH=0: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=mem_ready, PCWrite=mem_ready. Stays in FETCH until mem_ready=1, then goes to DECODE.
  - DECODE=1: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute). Next state by opcode:
    - 0 -> R_EXEC
    - 35 or 43 -> MEM_ADDR
    - 4 -> BRANCH
    - 2 -> JUMP
    - any other opcode -> FETCH, with illegal_op=1 for this cycle.
  - MEM_ADDR=2: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: opcode 35 -> MEM_READ, opcode 43 -> MEM_WRITE.
  - MEM_READ=3: MemRead=1, IorD=1. Held until mem_ready=1, then goes to MEM_WB.
  - MEM_WB=4: RegDst=0, MemtoReg=1, RegWrite=1. Next: FETCH.
  - MEM_WRITE=5: MemWrite=1, IorD=1. Held until mem_ready=1, then goes to FETCH. MemWrite stays high for the whole wait.
  - R_EXEC=6: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: R_WB.
  - R_WB=7: RegDst=1, MemtoReg=0, RegWrite=1. Next: FETCH.
  - BRANCH=8: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next: FETCH.
  - JUMP=9: PCWrite=1, PCSource=10. Next: FETCH.
  - Encodings 10-15 when the optional feature is absent, and 12-15 always, are unreachable. If reached, next state is FETCH.
- Latency in cycles, with mem_ready tied to 1 (FETCH to the next FETCH):
  - R-type: 4
  - lw: 5
  - sw: 4
  - beq: 3
  - j: 3
  - illegal opcode: 2
- Each wait cycle on mem_ready adds exactly 1 cycle.
- opcode is sampled only in DECODE and MEM_ADDR. It is stable from IR.
- Reset asserted mid-instruction, including during a MEM_WRITE wait: the state resets immediately and MemWrite drops asynchronously.

Optional Feature:
- Macro: MIPS_CTRL_ADDI_EN.
- When defined:
  - DECODE sends opcode 8 to ADDI_EXEC=10.
  - ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: ADDI_WB=11.
  - ADDI_WB: RegDst=0, MemtoReg=0, RegWrite=1. Next: FETCH.
  - addi latency is 4 cycles.
- When undefined: opcode 8 is illegal (illegal_op pulse, return to FETCH).

Decomposition:
- Package mips_ctrl_pkg holds:
  - the state encoding constants
  - the opcode constants (OP_RTYPE=0, OP_J=2, OP_BEQ=4, OP_ADDI=8, OP_LW=35, OP_SW=43)
  - ALUOp constants (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNC=10)
  - PCSource and ALUSrcB select constants
- One sub-module: multicycle_ctrl_outdec, a combinational state-to-outputs decoder.
  - Inputs: state and mem_ready.
- The top level holds the state register, next-state logic and reset gating.

Test Plan:
- Reset during a MEM_WRITE wait (mem_ready=0): MemWrite falls without waiting for a clock edge, state_out=0, and all enables are 0 until reset is released.
- R-type (opcode 0), mem_ready=1: state_out sequence 0,1,6,7,0. ALUOp=10 in state 6. RegWrite=1 and RegDst=1 only in state 7.
- lw (opcode 35) with mem_ready low for 2 cycles in MEM_READ: sequence 0,1,2,3,3,3,4,0. MemRead=1 and IorD=1 across all three state-3 cycles.
- FETCH with mem_ready low for 3 cycles: IRWrite=0 and PCWrite=0 for 3 cycles, then both are 1 for exactly one cycle, then DECODE.
- beq (opcode 4): sequence 0,1,8,0 with ALUOp=01, PCWriteCond=1, PCSource=01 in state 8. j (opcode 2): sequence 0,1,9,0 with PCWrite=1 and PCSource=10.
- Opcode 8:
  - Macro undefined: illegal_op=1 in the DECODE cycle only, then FETCH.
  - MIPS_CTRL_ADDI_EN defined: sequence 0,1,10,11,0 with RegWrite=1 and RegDst=0 in state 11.
